// File: rtl/bus_reg_writer.sv
// bus_reg_writer
//   Destination side of the 32-source bus multiplexer. Write requests
//   (5-bit destination code, 32-bit value) arrive over a valid/ready
//   handshake. They are queued in a small FIFO and retired one per clock
//   into the writable register bank:
//     codes 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = Z_HI, 19 = Z_LO,
//     20 = PC, 21 = MDR.
//   Codes 22-31 are read-only or unused. A write to one of them is dropped
//   and flagged on err_ro.
//
// Ports
//   clock       rising-edge clock
//   clear       asynchronous active-high reset
//   wr_valid    write request present
//   wr_ready    request can be accepted this cycle (registered state only)
//   wr_dest     destination code, same encoding as the bus mux select
//   wr_data     value to write
//   bank_flat   22x32 bank contents; code k occupies bits [32k+31:32k]
//   wr_strobe   one-hot, names the register that changed at the last edge
//   err_ro      one-cycle pulse: the retired request targeted a read-only code
//   fifo_count  number of queued entries
module bus_reg_writer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          clear,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [4:0]                    wr_dest,
   input  logic [31:0]                   wr_data,
   output logic [703:0]                  bank_flat,
   output logic [21:0]                   wr_strobe,
   output logic                          err_ro,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int NREGS  = 22;

   // Queue storage is data only and is not reset; the valid entries are
   // tracked by the pointers and the count.
   logic [4:0]        fifo_dest_q [FIFO_DEPTH];
   logic [31:0]       fifo_data_q [FIFO_DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [31:0]       bank_q [NREGS];
   logic [31:0]       bank_d [NREGS];
   logic [21:0]       strobe_q, strobe_d;
   logic              err_q, err_d;

   logic              push;
   logic              pop;
   logic [4:0]        head_dest;
   logic [31:0]       head_data;

   // Fullness and emptiness come from the count, never from pointer equality.
   assign wr_ready  = (count_q < CNT_W'(FIFO_DEPTH));
   assign push      = wr_valid && wr_ready;
   assign pop       = (count_q != '0);
   assign head_dest = fifo_dest_q[head_q];
   assign head_data = fifo_data_q[head_q];

   // ---- next-state: pointers and count ----
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      // A push and a pop on the same edge leave the count unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ---- next-state: retire the head entry into the bank ----
   // The head is read from registered storage, so an entry pushed on this
   // edge cannot be retired on the same edge (no bypass).
   always_comb begin
      for (int k = 0; k < NREGS; k++) begin
         bank_d[k] = bank_q[k];
      end
      strobe_d = '0;
      err_d    = 1'b0;
      if (pop) begin
         if (head_dest < 5'(NREGS)) begin
            for (int k = 0; k < NREGS; k++) begin
               if (head_dest == 5'(k)) begin
                  bank_d[k]   = head_data;
                  strobe_d[k] = 1'b1;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // ---- registers ----
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         strobe_q <= '0;
         err_q    <= 1'b0;
         for (int k = 0; k < NREGS; k++) begin
            bank_q[k] <= '0;
         end
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
         for (int k = 0; k < NREGS; k++) begin
            bank_q[k] <= bank_d[k];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_dest_q[tail_q] <= wr_dest;
         fifo_data_q[tail_q] <= wr_data;
      end
   end

   // ---- outputs ----
   for (genvar k = 0; k < NREGS; k++) begin : g_flat
      assign bank_flat[32*k +: 32] = bank_q[k];
   end

   assign wr_strobe  = strobe_q;
   assign err_ro     = err_q;
   assign fifo_count = count_q;

endmodule
